// File: rtl/mealy_mac_n_pkg.sv
// Shared types, clamp helpers and packing functions for the multi-channel
// signed multiply-accumulate block (mealy_mac_n) and its saturation stage.
// No ports; imported by mealy_mac_sat and mealy_mac_n.
package mealy_mac_n_types;

  // Widest accumulator / channel index any instance may use.
  localparam int unsigned ACC_W_MAX = 64;
  localparam int unsigned CH_W_MAX  = 16;

  // Accumulator state: one signed running value plus the channel that owns it.
  typedef struct packed {
    logic [CH_W_MAX-1:0]         ch;
    logic signed [ACC_W_MAX-1:0] acc;
  } acc_state_t;

  // Result word as presented downstream.
  typedef struct packed {
    logic                        valid;
    logic                        sat;
    logic [CH_W_MAX-1:0]         ch;
    logic signed [ACC_W_MAX-1:0] acc;
  } out_word_t;

  // Largest positive value of a w-bit signed number, held in ACC_W_MAX bits.
  function automatic logic [ACC_W_MAX-1:0] ACC_MAX(input int unsigned w);
    return (ACC_W_MAX'(1) << (w - 1)) - ACC_W_MAX'(1);
  endfunction

  // Most negative w-bit signed value; only the low w bits are meaningful.
  function automatic logic [ACC_W_MAX-1:0] ACC_MIN(input int unsigned w);
    return ~ACC_MAX(w);
  endfunction

  function automatic logic [CH_W_MAX+ACC_W_MAX-1:0] state_to_lv(input acc_state_t s);
    return {s.ch, s.acc};
  endfunction

  function automatic logic [CH_W_MAX+ACC_W_MAX+1:0] out_to_lv(input out_word_t o);
    return {o.valid, o.sat, o.ch, o.acc};
  endfunction

endpackage

// File: rtl/mealy_mac_sat.sv
// Combinational ACC_W+1 -> ACC_W reduction: two's-complement wrap, or clamp
// to the signed ACC_W range when SATURATE is set.
// Ports:
//   i_sum    ACC_W+1 signed  wide sum
//   o_acc_c  ACC_W signed    reduced value
//   o_sat_c  1               clamping happened (always 0 in wrap mode)
module mealy_mac_sat
  import mealy_mac_n_types::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter bit          SATURATE = 1'b0
) (
  input  logic signed [ACC_W:0]   i_sum,
  output logic signed [ACC_W-1:0] o_acc_c,
  output logic                    o_sat_c
);

  localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'(ACC_MAX(ACC_W));
  localparam logic signed [ACC_W-1:0] W_MIN = ACC_W'(ACC_MIN(ACC_W));

  logic w_ovf;

  // Overflow: the guard bit disagrees with the ACC_W sign bit.
  always_comb begin
    w_ovf   = i_sum[ACC_W] ^ i_sum[ACC_W-1];
    o_acc_c = i_sum[ACC_W-1:0];
    o_sat_c = 1'b0;
    if (SATURATE && w_ovf) begin
      o_acc_c = i_sum[ACC_W] ? W_MIN : W_MAX;
      o_sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/mealy_mac_n.sv
// Multi-channel signed multiply-accumulate with valid/ready streams.
// Stage 1 registers x*y with its channel/clear tag; stage 2 adds (or loads)
// the product into that channel's accumulator and presents the new value.
// Ports:
//   system1000 / system1000_rstn   clock, async active-low reset
//   in_valid/in_ready               input handshake (in_ready = advance enable)
//   in_ch, in_x, in_y, in_clr       channel, signed operands, load-instead-of-add
//   out_valid/out_ready             output handshake
//   out_ch, out_acc, out_sat        channel, new accumulator, clamp flag
module mealy_mac_n
  import mealy_mac_n_types::*;
#(
  parameter  int unsigned DATA_W   = 9,
  parameter  int unsigned ACC_W    = 24,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned SATURATE = 0,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic                     in_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_sat
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mealy_mac_n: ACC_W must be at least 2*DATA_W");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("mealy_mac_n: CHANNELS must be at least 1");
  end

  logic                     w_en;
  logic                     w_ch_ok;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_rd;
  logic signed [ACC_W:0]    w_p;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W-1:0]  w_res;
  logic                     w_sat;

  logic                     r_s1_v;
  logic                     r_s1_clr;
  logic [CH_W-1:0]          r_s1_ch;
  logic signed [PROD_W-1:0] r_s1_prod;

  logic signed [ACC_W-1:0]  r_acc [CHANNELS];

  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [ACC_W-1:0]  r_out_acc;
  logic                     r_out_sat;

  // Both stages advance together; a held result freezes the whole pipe.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Zero-extend before comparing so the test stays meaningful for any CH_W.
  assign w_ch_ok = 32'(in_ch) < CHANNELS;
  assign w_prod  = PROD_W'(in_x) * PROD_W'(in_y);

  // Accumulators are written only here, so a same-channel beat right behind
  // sees the value written on the previous edge without forwarding.
  assign w_acc_rd = r_acc[r_s1_ch];
  assign w_p      = (ACC_W + 1)'(r_s1_prod);
  assign w_sum    = r_s1_clr ? w_p : ((ACC_W + 1)'(w_acc_rd) + w_p);

  mealy_mac_sat #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE != 0)
  ) u_sat (
    .i_sum   (w_sum),
    .o_acc_c (w_res),
    .o_sat_c (w_sat)
  );

  // Stage registers, accumulator array and output word.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_s1_v      <= 1'b0;
      r_s1_clr    <= 1'b0;
      r_s1_ch     <= '0;
      r_s1_prod   <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_acc   <= '0;
      r_out_sat   <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_en) begin
      // Out-of-range channels are accepted but never reach stage 2.
      r_s1_v      <= in_valid && w_ch_ok;
      r_s1_clr    <= in_clr;
      r_s1_ch     <= in_ch;
      r_s1_prod   <= w_prod;
      r_out_valid <= r_s1_v;
      if (r_s1_v) begin
        r_acc[r_s1_ch] <= w_res;
        r_out_acc      <= w_res;
        r_out_ch       <= r_s1_ch;
        r_out_sat      <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_acc   = r_out_acc;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_mealy_mac_n.sv
// Bench for mealy_mac_n: three instances (default wrap/24-bit, 18-bit clamp,
// 18-bit wrap) share one input stream; an arithmetic reference model checks
// every cycle, and directed literals pin the key values.
module tb_mealy_mac_n;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] in_ch = '0;
  logic signed [8:0] in_x = '0;
  logic signed [8:0] in_y = '0;
  logic in_clr = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic [1:0] out_ch0, out_ch1, out_ch2;
  logic signed [23:0] out_acc0;
  logic signed [17:0] out_acc1, out_acc2;
  logic out_sat0, out_sat1, out_sat2;

  always #5 clk = ~clk;

  mealy_mac_n dut0 (
    .system1000(clk), .system1000_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_clr(in_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ch(out_ch0),
    .out_acc(out_acc0), .out_sat(out_sat0)
  );

  mealy_mac_n #(.ACC_W(18), .SATURATE(1)) dut1 (
    .system1000(clk), .system1000_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_clr(in_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ch(out_ch1),
    .out_acc(out_acc1), .out_sat(out_sat1)
  );

  mealy_mac_n #(.ACC_W(18), .SATURATE(0)) dut2 (
    .system1000(clk), .system1000_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_clr(in_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2),
    .out_acc(out_acc2), .out_sat(out_sat2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     ch;
    longint a0, a1, a2;
    bit     s0, s1, s2;
    int     rdy;
  } exp_t;

  exp_t   q[$];
  longint ma0 [4];
  longint ma1 [4];
  longint ma2 [4];
  int     k = 0;
  bit     exp_v, exp_ir;

  function automatic void mstep(input longint acc, input longint p, input bit clr,
                                input int w, input bit sat,
                                output longint res, output bit s);
    longint mx, mn, sum;
    mx  = (64'sd1 <<< (w - 1)) - 1;
    mn  = -mx - 1;
    sum = clr ? p : acc + p;
    res = sum;
    s   = 1'b0;
    if (sum > mx) begin
      if (sat) begin res = mx; s = 1'b1; end
      else res = sum - (64'sd1 <<< w);
    end else if (sum < mn) begin
      if (sat) begin res = mn; s = 1'b1; end
      else res = sum + (64'sd1 <<< w);
    end
  endfunction

  // Checks all three instances just before each rising edge.
  always @(negedge clk) begin
    #4;
    k++;
    if (!rstn) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin ma0[i] = 0; ma1[i] = 0; ma2[i] = 0; end
      chk("rst_ov0", longint'(out_valid0), 0);
      chk("rst_ov1", longint'(out_valid1), 0);
      chk("rst_ov2", longint'(out_valid2), 0);
      chk("rst_ir0", longint'(in_ready0), 1);
      chk("rst_acc0", out_acc0, 0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].rdy <= k);
      chk("ov0", longint'(out_valid0), longint'(exp_v));
      chk("ov1", longint'(out_valid1), longint'(exp_v));
      chk("ov2", longint'(out_valid2), longint'(exp_v));
      if (exp_v) begin
        chk("ch0", longint'(out_ch0), q[0].ch);
        chk("ch1", longint'(out_ch1), q[0].ch);
        chk("ch2", longint'(out_ch2), q[0].ch);
        chk("acc0", out_acc0, q[0].a0);
        chk("acc1", out_acc1, q[0].a1);
        chk("acc2", out_acc2, q[0].a2);
        chk("sat0", longint'(out_sat0), longint'(q[0].s0));
        chk("sat1", longint'(out_sat1), longint'(q[0].s1));
        chk("sat2", longint'(out_sat2), longint'(q[0].s2));
      end
      exp_ir = !exp_v || out_ready;
      chk("ir0", longint'(in_ready0), longint'(exp_ir));
      chk("ir1", longint'(in_ready1), longint'(exp_ir));
      chk("ir2", longint'(in_ready2), longint'(exp_ir));
      if (exp_v && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        exp_t e;
        longint p;
        p     = longint'(in_x) * longint'(in_y);
        e.ch  = int'(in_ch);
        mstep(ma0[e.ch], p, in_clr, 24, 1'b0, e.a0, e.s0);
        mstep(ma1[e.ch], p, in_clr, 18, 1'b1, e.a1, e.s1);
        mstep(ma2[e.ch], p, in_clr, 18, 1'b0, e.a2, e.s2);
        ma0[e.ch] = e.a0;
        ma1[e.ch] = e.a1;
        ma2[e.ch] = e.a2;
        e.rdy = k + 2;
        q.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int ch, input int x, input int y, input bit clr);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_x     = 9'(x);
    in_y     = 9'(y);
    in_clr   = clr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_clr   = 1'b0;
  endtask

  task automatic beat(input int ch, input int x, input int y, input bit clr);
    drive(ch, x, y, clr);
    step();
  endtask

  // Holds the beat until the handshake completes.
  task automatic send(input int ch, input int x, input int y, input bit clr);
    int n;
    n = 0;
    drive(ch, x, y, clr);
    while (in_ready0 !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", n, 0);
    step();
  endtask

  task automatic expect_out(input string nm, input int ch, input longint acc);
    chk({nm, "_valid"}, longint'(out_valid0), 1);
    chk({nm, "_ch"}, longint'(out_ch0), ch);
    chk({nm, "_acc"}, out_acc0, acc);
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b1;
    rstn = 1'b0;
    #1;
    chk("reset_ov_now", longint'(out_valid0), 0);
    repeat (3) step();
    chk("reset_acc", out_acc0, 0);
    chk("reset_ir", longint'(in_ready0), 1);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    // Reset and first beat
    do_reset();
    beat(0, 1, 1, 1'b0);
    idle();
    step();
    expect_out("t1", 0, 1);

    // Accumulate on ch0
    do_reset();
    beat(0, 3, 4, 1'b0);
    beat(0, -5, 2, 1'b0);
    expect_out("acc_a", 0, 12);
    beat(0, 255, 255, 1'b0);
    expect_out("acc_b", 0, 2);
    idle();
    step();
    expect_out("acc_c", 0, 65027);

    // Channel isolation and clear
    beat(1, 10, 10, 1'b0);
    beat(2, -256, -256, 1'b0);
    expect_out("iso_a", 1, 100);
    beat(1, 1, 1, 1'b1);
    expect_out("iso_b", 2, 65536);
    beat(0, 0, 0, 1'b0);
    expect_out("iso_c", 1, 1);
    idle();
    step();
    expect_out("iso_d", 0, 65027);

    // Overflow on the 18-bit instances
    do_reset();
    beat(0, 255, 255, 1'b0);
    beat(0, 255, 255, 1'b0);
    chk("ovf_a", out_acc1, 65025);
    beat(0, 255, 255, 1'b0);
    chk("ovf_b", out_acc1, 130050);
    idle();
    step();
    chk("ovf_sat_acc", out_acc1, 131071);
    chk("ovf_sat_flag", longint'(out_sat1), 1);
    chk("ovf_wrap_acc", out_acc2, -67069);
    chk("ovf_wrap_flag", longint'(out_sat2), 0);

    // Back-pressure during a 4-beat burst
    do_reset();
    fork
      begin
        send(3, 7, 8, 1'b0);
        send(3, -9, 3, 1'b0);
        send(3, 100, -50, 1'b0);
        send(3, -1, -1, 1'b0);
        idle();
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("stall_ir", longint'(in_ready0), 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("drain_timeout", n, 0);
    beat(3, 0, 0, 1'b0);
    idle();
    step();
    expect_out("bp_final", 3, -4970);

    // Reset with two beats in flight
    beat(0, 5, 5, 1'b0);
    beat(1, 6, 6, 1'b0);
    idle();
    rstn = 1'b0;
    #1;
    chk("mid_rst_ov0", longint'(out_valid0), 0);
    chk("mid_rst_ov1", longint'(out_valid1), 0);
    repeat (2) step();
    rstn = 1'b1;
    beat(0, 2, 3, 1'b0);
    idle();
    step();
    expect_out("post_rst", 0, 6);

    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mealy_mac_n.md
# mealy_mac_n

Parametrised, multi-channel successor to the two-register signed Mealy accumulator. The block accepts signed operand pairs tagged with a channel index, multiplies them, and accumulates each product into that channel's private accumulator. Each updated value is emitted on a valid/ready output stream. It sits between the sample source and downstream filter/decision logic, replacing one hand-instantiated Mealy machine per channel.

## Interface

- Clocking and reset are fixed: one clock, `system1000`; reset `system1000_rstn` is asynchronous and active-low.
- Parameters:
  - `DATA_W`, default 9: signed operand width.
  - `ACC_W`, default 24: signed accumulator width. Must be ≥ 2*`DATA_W`; violation is an elaboration error.
  - `CHANNELS`, default 4: number of independent accumulators, ≥ 1.
  - `SATURATE`, default 0: 0 = two's-complement wrap, 1 = clamp to the `ACC_W` signed range.
- `CH_W` = max(1, $clog2(`CHANNELS`)).
- Ports, clock and reset first:
  - `system1000`  in  1  clock.
  - `system1000_rstn`  in  1  async active-low reset.
  - `in_valid`  in  1  input beat present.
  - `in_ready`  out  1  block can accept a beat.
  - `in_ch`  in  `CH_W`  target channel; values ≥ `CHANNELS` are dropped.
  - `in_x`, `in_y`  in  `DATA_W` signed  operands.
  - `in_clr`  in  1  replace the accumulator with this product instead of adding it.
  - `out_valid`  out  1  result present.
  - `out_ready`  in  1  downstream accepts the result.
  - `out_ch`  out  `CH_W`  channel of the result.
  - `out_acc`  out  `ACC_W` signed  new accumulator value.
  - `out_sat`  out  1  clamping occurred on this beat (`SATURATE`=1 only; otherwise 0).

## Operation

- A beat is accepted when `in_valid && in_ready`.
- Pipeline advance enable `en = !out_valid || out_ready`. `in_ready = en`; this is combinational and carries no dependency on `in_valid`.
- Stage 1 (on `en`):
  - Register `in_x*in_y` as a full 2*`DATA_W` signed product, together with `in_ch`, `in_clr` and a valid bit `s1_v`.
  - Out-of-range `in_ch`: the beat is accepted but `s1_v` is forced to 0, so it is dropped silently.
- Stage 2 (on `en`, when `s1_v`):
  - `p` = product sign-extended to `ACC_W`+1.
  - `sum = s1_clr ? p : acc[s1_ch] + p`, computed in `ACC_W`+1 bits.
  - Overflow is defined as the top two bits of `sum` differing.
  - `SATURATE`=1: clamp to +2^(`ACC_W`-1)-1 or -2^(`ACC_W`-1) by sign, and set `out_sat`.
  - `SATURATE`=0: truncate to `ACC_W` bits; `out_sat`=0.
  - Write the result to `acc[s1_ch]` and to `out_acc`, copy `out_ch`, and set `out_valid`.
- Stage 2 with `en` and `!s1_v`: `out_valid` clears.
- Only stage 2 writes the accumulators, so a back-to-back same-channel beat reads the freshly written value. No forwarding is needed.
- A stall (`out_valid && !out_ready`) freezes both stages. All outputs hold stable and `acc` is unchanged.
- Reset value of every output: `out_valid`=0, `out_acc`=0, `out_ch`=0, `out_sat`=0.
- Reset value of internal state: all `acc` = 0, `s1_v`=0.
- `in_ready` reads 1 during and after reset.
- Reset asserted mid-operation: in-flight beats are discarded and all accumulators return to 0.

## Timing

- Latency is 2 cycles: a beat accepted at edge N appears on `out_*` after edge N+1.
- Full throughput of one beat per cycle while `out_ready`=1.
- Back-pressure propagates combinationally: `out_ready`→`in_ready`, depth 0.
- Outputs are registered; no combinational path from `in_*` to `out_*`.

## Structure

- Package `mealy_mac_n_types` holds:
  - the parametrised accumulator-state typedef, a generalisation of the two-field signed state struct;
  - the clamp constants (`ACC_MAX`, `ACC_MIN`);
  - the `*_to_lv` packing functions for the state and output words.
- Sub-module `mealy_mac_sat`: combinational `ACC_W`+1 → `ACC_W` wrap/clamp with overflow flag, parametrised by `ACC_W` and `SATURATE`.
- Top-level holds the stage registers, the accumulator array (`CHANNELS` × `ACC_W` flops) and the handshake logic.

## Test plan

- Reset: hold `system1000_rstn`=0 for 3 cycles → `out_valid`=0, `out_acc`=0, `in_ready`=1. Then on ch0, x=1, y=1 → `out_acc`=1.
- Accumulate (defaults): ch0 beats (3,4), (-5,2), (255,255) on consecutive cycles → `out_acc` = 12, 2, 65027 on cycles 2, 3, 4.
- Channel isolation and clear: ch1 (10,10); ch2 (-256,-256); ch1 (1,1) with `in_clr`=1 → ch1 results 100 then 1; ch2 = 65536; ch0 unaffected.
- Overflow, `ACC_W`=18, three ch0 beats of (255,255):
  - `SATURATE`=1 → 65025, 130050, 131071 with `out_sat`=1 on the third beat;
  - `SATURATE`=0 → third result is -67069 with `out_sat`=0.
- Back-pressure: `out_ready`=0 for 5 cycles during a 4-beat burst → `in_ready`=0 while stalled, `out_*` stable, no beat lost or duplicated; final accumulator matches the reference sum.
- Reset mid-stream: assert reset with two beats in flight → `out_valid` drops immediately. After release, ch0 (2,3) → `out_acc`=6.
